rob_param: RTL

- Parametrised reorder buffer for the out-of-order RV32I core. Sits between decoder/dispatch and the architectural commit consumers: register file, memory controller, branch predictor and fetch.
- Successor to the fixed 32-entry ROB, with these changes:
  - configurable depth;
  - configurable number of write-back (CDB) channels;
  - working operand-lookup bypass;
  - exact full/count reporting;
  - sticky halt on EXIT.
- Commits at most one entry per cycle, in order.

---
 rtl/rob_param_pkg.sv | 34 +++
 rtl/rob_lookup_mux.sv | 33 +++
 rtl/rob_param.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rob_param_pkg.sv
// Shared definitions for the parametrised reorder buffer: entry/store type codes,
// per-slot state encoding and the default geometry.
package rob_param_pkg;

    localparam int unsigned ROB_DEPTH_DEF = 16;
    localparam int unsigned ROB_ID_W_DEF  = $clog2(ROB_DEPTH_DEF);

    typedef enum logic [2:0] {
        ET_SB     = 3'd0,
        ET_SH     = 3'd1,
        ET_SW     = 3'd2,
        ET_REG    = 3'd3,
        ET_JALR   = 3'd4,
        ET_BRANCH = 3'd5,
        ET_EXIT   = 3'd6
    } entry_type_e;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_type_e;

    typedef enum logic [1:0] {
        SLOT_EMPTY   = 2'd0,
        SLOT_PENDING = 2'd1,
        SLOT_READY   = 2'd2
    } slot_state_e;

    function automatic logic is_store(input entry_type_e t);
        return (t == ET_SB) || (t == ET_SH) || (t == ET_SW);
    endfunction

endpackage

// File: rtl/rob_lookup_mux.sv
// Operand lookup for one source: CDB bypass (lowest channel wins) over the stored
// entry value; empty slots never report found.
module rob_lookup_mux
    import rob_param_pkg::*;
#(
    parameter int unsigned ID_W    = ROB_ID_W_DEF,
    parameter int unsigned CDB_NUM = 2
) (
    input  logic [ID_W-1:0]        q_id_i,
    input  slot_state_e            slot_state_i,
    input  logic [31:0]            slot_value_i,
    input  logic [CDB_NUM-1:0]     cdb_valid_i,
    input  logic [CDB_NUM*ID_W-1:0] cdb_id_i,
    input  logic [CDB_NUM*32-1:0]  cdb_value_i,
    output logic                   found_o,
    output logic [31:0]            value_o
);

    logic hit;

    always_comb begin
        hit     = 1'b0;
        value_o = slot_value_i;
        for (int unsigned k = 0; k < CDB_NUM; k++) begin
            if (!hit && cdb_valid_i[k] && (cdb_id_i[k*ID_W +: ID_W] == q_id_i)) begin
                hit     = 1'b1;
                value_o = cdb_value_i[k*32 +: 32];
            end
        end
        found_o = (slot_state_i != SLOT_EMPTY) && ((slot_state_i == SLOT_READY) || hit);
    end

endmodule

// File: rtl/rob_param.sv
// Parametrised in-order-commit reorder buffer: dispatch at tail, CDB/store
// write-back, bypassed operand lookup and one registered commit per cycle.
module rob_param
    import rob_param_pkg::*;
#(
    parameter int unsigned DEPTH   = ROB_DEPTH_DEF,
    parameter int unsigned ID_W    = $clog2(DEPTH),
    parameter int unsigned CDB_NUM = 2,
    parameter int unsigned REG_W   = 5
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    dec_valid,
    input  logic [2:0]              dec_type,
    input  logic [REG_W-1:0]        dec_rd,
    input  logic [31:0]             dec_value,
    input  logic                    dec_ready,
    input  logic [31:0]             dec_pc,
    input  logic [31:0]             dec_pred_addr,
    input  logic                    dec_pred_taken,
    output logic                    alloc_ready,
    output logic [ID_W-1:0]         alloc_id,
    output logic [ID_W:0]           count_out,
    input  logic [CDB_NUM-1:0]      cdb_valid,
    input  logic [CDB_NUM*ID_W-1:0] cdb_id,
    input  logic [CDB_NUM*32-1:0]   cdb_value,
    input  logic                    st_valid,
    input  logic [ID_W-1:0]         st_id,
    input  logic [31:0]             st_addr,
    input  logic [31:0]             st_data,
    input  logic                    mem_busy,
    input  logic [ID_W-1:0]         q1_id,
    input  logic [ID_W-1:0]         q2_id,
    output logic                    q1_found,
    output logic                    q2_found,
    output logic [31:0]             q1_value,
    output logic [31:0]             q2_value,
    output logic                    rf_we,
    output logic [REG_W-1:0]        rf_rd,
    output logic [31:0]             rf_value,
    output logic [ID_W-1:0]         rf_id,
    output logic                    mem_we,
    output logic [1:0]              mem_type,
    output logic [31:0]             mem_addr,
    output logic [31:0]             mem_data,
    output logic                    sb_pop,
    output logic                    pred_we,
    output logic [31:0]             pred_pc,
    output logic                    pred_taken,
    output logic                    flush_out,
    output logic [31:0]             flush_addr,
    output logic                    halt_out
);

    logic [ID_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [ID_W:0]    count_q, count_d;
    slot_state_e      state_q [DEPTH];
    slot_state_e      state_d [DEPTH];

    entry_type_e      type_q      [DEPTH];
    logic [REG_W-1:0] rd_q        [DEPTH];
    logic [31:0]      value_q     [DEPTH];
    logic [31:0]      pc_q        [DEPTH];
    logic [31:0]      pred_addr_q [DEPTH];
    logic             pred_tk_q   [DEPTH];
    logic [31:0]      st_addr_q   [DEPTH];
    logic [31:0]      st_data_q   [DEPTH];

    logic             rf_we_q, rf_we_d;
    logic [REG_W-1:0] rf_rd_q, rf_rd_d;
    logic [31:0]      rf_value_q, rf_value_d;
    logic [ID_W-1:0]  rf_id_q, rf_id_d;
    logic             mem_we_q, mem_we_d;
    mem_type_e        mem_type_q, mem_type_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_data_q, mem_data_d;
    logic             sb_pop_q, sb_pop_d;
    logic             pred_we_q, pred_we_d;
    logic [31:0]      pred_pc_q, pred_pc_d;
    logic             pred_taken_q, pred_taken_d;
    logic             flush_q, flush_d;
    logic [31:0]      flush_addr_q, flush_addr_d;
    logic             halt_q, halt_d;

    logic             full, active, head_ready, commit, dispatch;
    entry_type_e      h_type;
    logic [31:0]      h_value, h_pc, h_pred_addr, h_pc4;

    assign full        = (count_q == (ID_W+1)'(DEPTH));
    assign alloc_ready = !full;
    assign alloc_id    = tail_q;
    assign count_out   = count_q;

    assign h_type      = type_q[head_q];
    assign h_value     = value_q[head_q];
    assign h_pc        = pc_q[head_q];
    assign h_pred_addr = pred_addr_q[head_q];
    assign h_pc4       = h_pc + 32'd4;

    // The flush cycle itself is dead: no write-back, dispatch or commit is taken.
    assign active     = rdy_in && !flush_q;
    assign head_ready = (count_q != '0) && (state_q[head_q] == SLOT_READY) && !halt_q;
    assign commit     = active && head_ready && !(is_store(h_type) && mem_busy);
    assign dispatch   = active && dec_valid && !full;

    rob_lookup_mux #(.ID_W(ID_W), .CDB_NUM(CDB_NUM)) u_lookup1 (
        .q_id_i       (q1_id),
        .slot_state_i (state_q[q1_id]),
        .slot_value_i (value_q[q1_id]),
        .cdb_valid_i  (cdb_valid),
        .cdb_id_i     (cdb_id),
        .cdb_value_i  (cdb_value),
        .found_o      (q1_found),
        .value_o      (q1_value)
    );

    rob_lookup_mux #(.ID_W(ID_W), .CDB_NUM(CDB_NUM)) u_lookup2 (
        .q_id_i       (q2_id),
        .slot_state_i (state_q[q2_id]),
        .slot_value_i (value_q[q2_id]),
        .cdb_valid_i  (cdb_valid),
        .cdb_id_i     (cdb_id),
        .cdb_value_i  (cdb_value),
        .found_o      (q2_found),
        .value_o      (q2_value)
    );

    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        state_d      = state_q;
        rf_we_d      = rf_we_q;
        rf_rd_d      = rf_rd_q;
        rf_value_d   = rf_value_q;
        rf_id_d      = rf_id_q;
        mem_we_d     = mem_we_q;
        mem_type_d   = mem_type_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        sb_pop_d     = sb_pop_q;
        pred_we_d    = pred_we_q;
        pred_pc_d    = pred_pc_q;
        pred_taken_d = pred_taken_q;
        flush_d      = flush_q;
        flush_addr_d = flush_addr_q;
        halt_d       = halt_q;

        if (rdy_in) begin
            rf_we_d   = 1'b0;
            mem_we_d  = 1'b0;
            sb_pop_d  = 1'b0;
            pred_we_d = 1'b0;
            flush_d   = 1'b0;

            if (flush_q) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
                for (int unsigned i = 0; i < DEPTH; i++) state_d[i] = SLOT_EMPTY;
            end else begin
                for (int unsigned k = 0; k < CDB_NUM; k++) begin
                    if (cdb_valid[k] && state_q[cdb_id[k*ID_W +: ID_W]] != SLOT_EMPTY)
                        state_d[cdb_id[k*ID_W +: ID_W]] = SLOT_READY;
                end
                if (st_valid && state_q[st_id] != SLOT_EMPTY)
                    state_d[st_id] = SLOT_READY;

                if (commit) begin
                    state_d[head_q] = SLOT_EMPTY;
                    head_d          = head_q + 1'b1;
                    unique case (h_type)
                        ET_REG: begin
                            rf_we_d    = 1'b1;
                            rf_rd_d    = rd_q[head_q];
                            rf_value_d = h_value;
                            rf_id_d    = head_q;
                        end
                        ET_JALR: begin
                            rf_we_d    = 1'b1;
                            rf_rd_d    = rd_q[head_q];
                            rf_value_d = h_pc4;
                            rf_id_d    = head_q;
                            if (h_value != h_pred_addr) begin
                                flush_d      = 1'b1;
                                flush_addr_d = h_value;
                            end
                        end
                        ET_BRANCH: begin
                            pred_we_d    = 1'b1;
                            pred_pc_d    = h_pc;
                            pred_taken_d = h_value[0];
                            if (h_value[0] != pred_tk_q[head_q]) begin
                                flush_d      = 1'b1;
                                flush_addr_d = h_value[0] ? h_pred_addr : h_pc4;
                            end
                        end
                        ET_SB, ET_SH, ET_SW: begin
                            mem_we_d   = 1'b1;
                            sb_pop_d   = 1'b1;
                            mem_type_d = mem_type_e'(h_type[1:0]);
                            mem_addr_d = st_addr_q[head_q];
                            mem_data_d = st_data_q[head_q];
                        end
                        ET_EXIT: halt_d = 1'b1;
                        default: ;
                    endcase
                end

                if (dispatch) begin
                    state_d[tail_q] = dec_ready ? SLOT_READY : SLOT_PENDING;
                    tail_d          = tail_q + 1'b1;
                end

                unique case ({dispatch, commit})
                    2'b10:   count_d = count_q + 1'b1;
                    2'b01:   count_d = count_q - 1'b1;
                    default: count_d = count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) state_q[i] <= SLOT_EMPTY;
            rf_we_q      <= 1'b0;
            rf_rd_q      <= '0;
            rf_value_q   <= '0;
            rf_id_q      <= '0;
            mem_we_q     <= 1'b0;
            mem_type_q   <= MEM_BYTE;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            sb_pop_q     <= 1'b0;
            pred_we_q    <= 1'b0;
            pred_pc_q    <= '0;
            pred_taken_q <= 1'b0;
            flush_q      <= 1'b0;
            flush_addr_q <= '0;
            halt_q       <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            state_q      <= state_d;
            rf_we_q      <= rf_we_d;
            rf_rd_q      <= rf_rd_d;
            rf_value_q   <= rf_value_d;
            rf_id_q      <= rf_id_d;
            mem_we_q     <= mem_we_d;
            mem_type_q   <= mem_type_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            sb_pop_q     <= sb_pop_d;
            pred_we_q    <= pred_we_d;
            pred_pc_q    <= pred_pc_d;
            pred_taken_q <= pred_taken_d;
            flush_q      <= flush_d;
            flush_addr_q <= flush_addr_d;
            halt_q       <= halt_d;
        end
    end

    // Payload storage is deliberately unreset; slot state alone defines validity.
    always_ff @(posedge clk_in) begin
        if (active) begin
            for (int unsigned k = 0; k < CDB_NUM; k++) begin
                if (cdb_valid[k]) value_q[cdb_id[k*ID_W +: ID_W]] <= cdb_value[k*32 +: 32];
            end
            if (st_valid) begin
                st_addr_q[st_id] <= st_addr;
                st_data_q[st_id] <= st_data;
            end
            if (dispatch) begin
                type_q[tail_q]      <= entry_type_e'(dec_type);
                rd_q[tail_q]        <= dec_rd;
                value_q[tail_q]     <= dec_value;
                pc_q[tail_q]        <= dec_pc;
                pred_addr_q[tail_q] <= dec_pred_addr;
                pred_tk_q[tail_q]   <= dec_pred_taken;
            end
        end
    end

    assign rf_we      = rf_we_q;
    assign rf_rd      = rf_rd_q;
    assign rf_value   = rf_value_q;
    assign rf_id      = rf_id_q;
    assign mem_we     = mem_we_q;
    assign mem_type   = mem_type_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign sb_pop     = sb_pop_q;
    assign pred_we    = pred_we_q;
    assign pred_pc    = pred_pc_q;
    assign pred_taken = pred_taken_q;
    assign flush_out  = flush_q;
    assign flush_addr = flush_addr_q;
    assign halt_out   = halt_q;

endmodule
